// File: rtl/kbd_event_ctrl.sv
// PS/2 scan-code decoder: pops one byte per 4-cycle minimum FSM pass and turns E0/F0 sequences into press/release events.
// Latency: rx_ready sampled at edge N -> pop strobe N+1..N+2 -> registered outputs at N+3; rx_ready is ignored outside IDLE.
module kbd_event_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       rx_data,
    input  logic             rx_ready,
    input  logic             rx_overflow,
    input  logic             clr_ovf,
    output logic             nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ev_valid,
    output logic             ev_make,
    output logic             ovf_flag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        POP    = 2'd1,
        GAP    = 2'd2,
        DECODE = 2'd3
    } state_t;

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    state_t           state, state_nxt;
    logic [7:0]       byte_q, byte_nxt;
    logic             ext_pend, ext_nxt;
    logic             brk_pend, brk_nxt;
    logic             nextdata_nxt;
    logic [7:0]       code_nxt;
    logic             kext_nxt;
    logic             held_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             evv_nxt;
    logic             evm_nxt;
    logic             ovf_nxt;

    // Prefixes seen by the decoder; an overflow in the DECODE cycle strips them.
    logic             ext_eff;
    logic             brk_eff;
    logic             same_key;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_nxt     = byte_q;
        ext_nxt      = ext_pend;
        brk_nxt      = brk_pend;
        nextdata_nxt = 1'b1;
        code_nxt     = key_code;
        kext_nxt     = key_ext;
        held_nxt     = key_held;
        cnt_nxt      = press_cnt;
        evv_nxt      = 1'b0;
        evm_nxt      = ev_make;
        ovf_nxt      = ovf_flag;

        ext_eff  = ext_pend & ~rx_overflow;
        brk_eff  = brk_pend & ~rx_overflow;
        same_key = ({ext_eff, byte_q} == {key_ext, key_code});

        case (state)
            IDLE: begin
                if (rx_ready) begin
                    byte_nxt  = rx_data;
                    state_nxt = POP;
                end
            end
            POP: begin
                nextdata_nxt = 1'b0;
                state_nxt    = GAP;
            end
            GAP: begin
                state_nxt = DECODE;
            end
            DECODE: begin
                state_nxt = IDLE;
                if (byte_q == BYTE_EXT) begin
                    ext_nxt = 1'b1;
                end else if (byte_q == BYTE_BRK) begin
                    brk_nxt = 1'b1;
                end else begin
                    ext_nxt = 1'b0;
                    brk_nxt = 1'b0;
                    if (brk_eff) begin
                        code_nxt = byte_q;
                        kext_nxt = ext_eff;
                        evv_nxt  = 1'b1;
                        evm_nxt  = 1'b0;
                        if (same_key) begin
                            held_nxt = 1'b0;
                        end
                    end else if (!(key_held && same_key)) begin
                        // Anything but a typematic repeat of the held key is a new press.
                        code_nxt = byte_q;
                        kext_nxt = ext_eff;
                        held_nxt = 1'b1;
                        cnt_nxt  = press_cnt + 1'b1;
                        evv_nxt  = 1'b1;
                        evm_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (rx_overflow) begin
            ext_nxt = 1'b0;
            brk_nxt = 1'b0;
            ovf_nxt = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            byte_q     <= 8'h00;
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            nextdata_n <= 1'b1;
            key_code   <= 8'h00;
            key_ext    <= 1'b0;
            key_held   <= 1'b0;
            press_cnt  <= '0;
            ev_valid   <= 1'b0;
            ev_make    <= 1'b0;
            ovf_flag   <= 1'b0;
        end else begin
            byte_q     <= byte_nxt;
            ext_pend   <= ext_nxt;
            brk_pend   <= brk_nxt;
            nextdata_n <= nextdata_nxt;
            key_code   <= code_nxt;
            key_ext    <= kext_nxt;
            key_held   <= held_nxt;
            press_cnt  <= cnt_nxt;
            ev_valid   <= evv_nxt;
            ev_make    <= evm_nxt;
            ovf_flag   <= ovf_nxt;
        end
    end

endmodule

// File: doc/kbd_event_ctrl.md
KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of press counter.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: resetn  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: rx_data  input  8  scan-code byte at head of PS/2 receiver FIFO.
REQ-005 SHALL have port: rx_ready  input  1  receiver FIFO non-empty; rx_data valid.
REQ-006 SHALL have port: rx_overflow  input  1  receiver FIFO overflow indication (level).
REQ-007 SHALL have port: clr_ovf  input  1  one-cycle request to clear ovf_flag.
REQ-008 SHALL have port: nextdata_n  output  1  active-low pop strobe to receiver FIFO.
REQ-009 SHALL have port: key_code  output  8  last make/break code decoded.
REQ-010 SHALL have port: key_ext  output  1  key_code was E0-prefixed.
REQ-011 SHALL have port: key_held  output  1  a key is currently pressed; doubles as display enable.
REQ-012 SHALL have port: press_cnt  output  CNT_W  count of distinct new presses.
REQ-013 SHALL have port: ev_valid  output  1  one-cycle event strobe.
REQ-014 SHALL have port: ev_make  output  1  qualifies ev_valid: 1 = press, 0 = release.
REQ-015 SHALL have port: ovf_flag  output  1  sticky receiver-overflow flag.

Function
REQ-016 SHALL make every output a register output.
REQ-017 SHALL implement FSM states IDLE, POP, GAP, DECODE.
REQ-018 IDLE: on rx_ready=1, SHALL latch rx_data into byte_q and go to POP; otherwise stay.
REQ-019 POP: SHALL drive nextdata_n=0 for exactly this one cycle, then go to GAP.
REQ-020 GAP: SHALL drive nextdata_n=1 for one cycle so the FIFO head updates, then go to DECODE.
REQ-021 DECODE: SHALL process byte_q per REQ-022..026, then return to IDLE; rx_ready is ignored outside IDLE.
REQ-022 Byte E0: SHALL set ext_pend; no output change.
REQ-023 Byte F0: SHALL set brk_pend; no output change.
REQ-024 Other byte with brk_pend=1:
- key_code<=byte and key_ext<=ext_pend.
- ev_valid pulse with ev_make=0.
- key_held<=0 only if {ext_pend,byte} equals the held {key_ext,key_code}; otherwise key_held unchanged.
REQ-025 Other byte with brk_pend=0, when key_held=1 and {ext_pend,byte} equals the held code: typematic repeat; SHALL produce no ev_valid, no counter change, no other output change.
REQ-026 Other byte with brk_pend=0, otherwise (new press):
- key_code<=byte, key_ext<=ext_pend, key_held<=1.
- press_cnt increments modulo 2^CNT_W (all-ones wraps to 0).
- ev_valid pulse with ev_make=1.
REQ-027 SHALL clear ext_pend and brk_pend after every non-prefix byte.
REQ-028 Latency: if rx_ready is sampled at edge N, nextdata_n SHALL be low between edges N+1 and N+2, and outputs and ev_valid SHALL update at edge N+3; minimum 4 cycles per byte.
REQ-029 ev_valid SHALL be high for exactly one cycle per event; ev_make SHALL hold its value until the next event.
REQ-030 rx_overflow=1 in any cycle SHALL set ovf_flag and clear ext_pend/brk_pend at that edge; if the FSM is in DECODE that cycle, byte_q SHALL still be decoded, without prefixes.
REQ-031 clr_ovf=1 SHALL clear ovf_flag; if rx_overflow=1 in the same cycle, set wins.

Reset
REQ-032 resetn=0 at a rising edge SHALL force, from any state:
- state IDLE, nextdata_n=1;
- key_code=0x00, key_ext=0, key_held=0, press_cnt=0;
- ev_valid=0, ev_make=0, ovf_flag=0;
- ext_pend=0, brk_pend=0.
REQ-033 Reset asserted mid-byte (POP/GAP/DECODE) SHALL discard byte_q with no pop completion or event.

Verification
REQ-034 Press A: rx byte 1C -> nextdata_n low one cycle, 3 cycles after acceptance key_code=1C, key_held=1, press_cnt=1, one ev_valid with ev_make=1.
REQ-035 Repeat then release: bytes 1C,1C,1C,F0,1C after REQ-034 -> no ev_valid for repeats, press_cnt=1; after F0 1C, key_held=0, key_code=1C, one ev_valid with ev_make=0.
REQ-036 Extended key: bytes E0,75 -> key_code=75, key_ext=1, press_cnt+1; then E0,F0,75 -> key_held=0; then plain 75 -> counted as a new press with key_ext=0.
REQ-037 Mismatched break: held 1C, bytes F0,1B -> ev_valid with ev_make=0, key_code=1B, key_held stays 1.
REQ-038 Wrap: 2^CNT_W alternating new presses (1C,1B,...) from reset -> press_cnt returns to 0.
REQ-039 Overflow/reset: rx_overflow pulse after byte F0, then byte 1C -> ovf_flag=1 and 1C is treated as a make; clr_ovf with rx_overflow=1 -> ovf_flag stays 1; resetn=0 during POP -> all outputs at reset values next cycle.
